// File: rtl/seq1101_scan_ctrl.sv
// rtl/seq1101_scan_ctrl.sv - launches, clears and streams a pattern through the 1101 detector
// Captures the detector's Mealy output per shifted bit into a match count and per-bit match map.
module seq1101_scan_ctrl #(
   parameter int N     = 16,
   parameter int CNT_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [N-1:0]     pattern,
   input  logic             det_z,
   output logic             det_x,
   output logic             det_clr,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] match_cnt,
   output logic [N-1:0]     match_map
);

   localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      CLEAR = 2'd1,
      SHIFT = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic               start_q, start_d;
   logic [N-1:0]       sreg_q, sreg_d;
   logic [IDX_W-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [N-1:0]       map_q, map_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               clr_q, clr_d;
   logic               launch;

   assign launch = start & ~start_q;

   always_comb begin
      state_d = state_q;
      start_d = start;
      sreg_d  = sreg_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      map_d   = map_q;
      busy_d  = busy_q;
      done_d  = done_q;
      clr_d   = clr_q;
      case (state_q)
         CLEAR: begin
            idx_d   = IDX_W'(N - 1);
            clr_d   = 1'b0;
            state_d = SHIFT;
         end
         SHIFT: begin
            // det_z belongs to the bit currently on det_x, i.e. pattern[idx]
            if (det_z) begin
               map_d[idx_q] = 1'b1;
               if (cnt_q != {CNT_W{1'b1}})
                  cnt_d = cnt_q + CNT_W'(1);
            end
            sreg_d = sreg_q << 1;
            idx_d  = idx_q - IDX_W'(1);
            if (idx_q == '0) begin
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               clr_d   = 1'b1;
            end
         end
         default: begin
            // IDLE, DONE and any undefined encoding behave alike
            clr_d  = 1'b1;
            busy_d = 1'b0;
            if (state_q != DONE)
               done_d = 1'b0;
            if (state_q != DONE && state_q != IDLE)
               state_d = IDLE;
            if (launch) begin
               sreg_d  = pattern;
               cnt_d   = '0;
               map_d   = '0;
               done_d  = 1'b0;
               busy_d  = 1'b1;
               state_d = CLEAR;
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         start_q <= 1'b1;
         sreg_q  <= '0;
         idx_q   <= '0;
         cnt_q   <= '0;
         map_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b1;
      end else begin
         state_q <= state_d;
         start_q <= start_d;
         sreg_q  <= sreg_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         map_q   <= map_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
      end
   end

   assign det_x     = (state_q == SHIFT) ? sreg_q[N-1] : 1'b0;
   assign det_clr   = clr_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign match_cnt = cnt_q;
   assign match_map = map_q;

endmodule

// File: tb/tb_seq1101_scan_ctrl.sv
// tb/tb_seq1101_scan_ctrl.sv - directed bench for seq1101_scan_ctrl with a 1101 Mealy detector model
module tb_seq1101_scan_ctrl;

   localparam int N     = 16;
   localparam int CNT_W = 5;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [N-1:0]     pattern;
   logic             det_z;
   logic             det_x;
   logic             det_clr;
   logic             busy;
   logic             done;
   logic [CNT_W-1:0] match_cnt;
   logic [N-1:0]     match_map;

   int n_checks = 0;
   int n_fails  = 0;

   always #5 clk = ~clk;

   seq1101_scan_ctrl #(.N(N), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .pattern   (pattern),
      .det_z     (det_z),
      .det_x     (det_x),
      .det_clr   (det_clr),
      .busy      (busy),
      .done      (done),
      .match_cnt (match_cnt),
      .match_map (match_map)
   );

   // detector: 0=idle, 1="1", 2="11", 3="110"; a match returns to "1"
   logic [1:0] dst;
   assign det_z = (dst == 2'd3) && det_x;
   always @(posedge clk) begin
      if (det_clr) dst <= 2'd0;
      else begin
         case (dst)
            2'd0: dst <= det_x ? 2'd1 : 2'd0;
            2'd1: dst <= det_x ? 2'd2 : 2'd0;
            2'd2: dst <= det_x ? 2'd2 : 2'd3;
            default: dst <= det_x ? 2'd1 : 2'd0;
         endcase
      end
   end

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; pattern = '0;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({busy, done, det_x, det_clr, match_cnt, match_map} !== {1'b0, 1'b0, 1'b0, 1'b1, 5'd0, 16'h0}) begin
         n_fails++;
         $display("FAIL reset_values: got busy=%b done=%b x=%b clr=%b cnt=%0d map=%h, want 0 0 0 1 0 0000",
                  busy, done, det_x, det_clr, match_cnt, match_map);
      end
      reset = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   // disturb=1: extra start pulse and pattern change mid-SHIFT; hold=1: start stays high through DONE
   task automatic scan(input string name, input logic [N-1:0] p, input logic [CNT_W-1:0] exp_cnt,
                       input logic [N-1:0] exp_map, input bit disturb, input bit hold);
      int busy_cycles;
      @(negedge clk);
      pattern = p; start = 1'b1;
      @(negedge clk);            // cycle k+1: CLEAR
      if (!hold) start = 1'b0;
      busy_cycles = busy ? 1 : 0;
      n_checks++;
      if (!(busy === 1'b1 && det_clr === 1'b1 && done === 1'b0)) begin
         n_fails++;
         $display("FAIL %s_clear: got busy=%b clr=%b done=%b, want 1 1 0", name, busy, det_clr, done);
      end
      for (int j = 0; j < N; j++) begin
         @(negedge clk);
         if (busy === 1'b1) busy_cycles++;
         n_checks++;
         if (det_x !== p[N-1-j] || det_clr !== 1'b0) begin
            n_fails++;
            $display("FAIL %s_shift%0d: got x=%b clr=%b, want x=%b clr=0", name, j, det_x, det_clr, p[N-1-j]);
         end
         if (disturb) begin
            if (j == 4) start = 1'b1;
            if (j == 5) begin start = 1'b0; pattern = 16'hFFFF; end
         end
      end
      @(negedge clk);            // cycle k+N+2: DONE
      n_checks++;
      if (!(done === 1'b1 && busy === 1'b0 && det_clr === 1'b1 && det_x === 1'b0)) begin
         n_fails++;
         $display("FAIL %s_done: got done=%b busy=%b clr=%b x=%b, want 1 0 1 0", name, done, busy, det_clr, det_x);
      end
      n_checks++;
      if (busy_cycles != N + 1) begin
         n_fails++;
         $display("FAIL %s_busy_len: got %0d, want %0d", name, busy_cycles, N + 1);
      end
      n_checks++;
      if (match_cnt !== exp_cnt || match_map !== exp_map) begin
         n_fails++;
         $display("FAIL %s_result: got cnt=%0d map=%h, want cnt=%0d map=%h", name, match_cnt, match_map, exp_cnt, exp_map);
      end
   endtask

   task automatic test_basic();
      scan("d000", 16'hD000, 5'd1, 16'h1000, 1'b0, 1'b0);
      scan("db6d", 16'hDB6D, 5'd5, 16'h1249, 1'b0, 1'b0);
   endtask

   task automatic test_edges();
      scan("ffff", 16'hFFFF, 5'd0, 16'h0000, 1'b0, 1'b0);
      scan("0000", 16'h0000, 5'd0, 16'h0000, 1'b0, 1'b0);
      scan("000d", 16'h000D, 5'd1, 16'h0001, 1'b0, 1'b0);
   endtask

   task automatic test_no_carry();
      scan("0006", 16'h0006, 5'd0, 16'h0000, 1'b0, 1'b0);
      scan("8000", 16'h8000, 5'd0, 16'h0000, 1'b0, 1'b0);
   endtask

   task automatic test_ignored_inputs();
      scan("hold", 16'hD000, 5'd1, 16'h1000, 1'b0, 1'b1);
      repeat (5) @(negedge clk);
      n_checks++;
      if (!(done === 1'b1 && busy === 1'b0 && match_map === 16'h1000)) begin
         n_fails++;
         $display("FAIL hold_no_relaunch: got done=%b busy=%b map=%h, want 1 0 1000", done, busy, match_map);
      end
      start = 1'b0;
      scan("disturb", 16'hD000, 5'd1, 16'h1000, 1'b1, 1'b0);
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      pattern = 16'hDB6D; start = 1'b1;
      @(negedge clk);            // CLEAR
      start = 1'b0;
      repeat (6) @(negedge clk); // SHIFT cycle 5
      start = 1'b1; reset = 1'b1;
      #1;
      n_checks++;
      if ({busy, done, det_clr, det_x, match_cnt, match_map} !== {1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 16'h0}) begin
         n_fails++;
         $display("FAIL reset_mid: got busy=%b done=%b clr=%b x=%b cnt=%0d map=%h, want 0 0 1 0 0 0000",
                  busy, done, det_clr, det_x, match_cnt, match_map);
      end
      @(negedge clk);
      reset = 1'b0;
      repeat (4) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || done !== 1'b0) begin
         n_fails++;
         $display("FAIL reset_no_launch: got busy=%b done=%b, want 0 0", busy, done);
      end
      start = 1'b0;
      scan("after_reset", 16'hDB6D, 5'd5, 16'h1249, 1'b0, 1'b0);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_edges();
      test_no_carry();
      test_ignored_inputs();
      test_reset_mid();
      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
